alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control unit that drives the 8-bit ALU's f select, write_cz enable and aBus operand.
- Accepts ALU commands over a valid/ready handshake and issues each command 1..2^CNT_W times.
- Can optionally stop early when the ALU zero flag is set; can be aborted.
- Reports completion with the final cBus result, CF/ZF and the number of issues; sits between the instruction decode/front end and the ALU instance.

Parameters:
- CNT_W, 4, width of the repeat count; a command issues at most 2^CNT_W times.
- DATA_W, 8, ALU data width; matches the ALU buses.

Ports:
- clk_SEQ  input  1  system clock, rising edge.
- rstn_SEQ  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (IDLE only).
- cmd_op  input  3  ALU function code (000 load A, 001 B=A, 010 A+1, 011 B+1, 100 A+B, 101 A-B, 110 A&B, 111 A|B).
- cmd_cnt  input  CNT_W  repeat count minus one.
- cmd_until_z  input  1  stop after the first issue that leaves ZF=1.
- cmd_data  input  DATA_W  operand driven on the ALU aBus for the whole command.
- abort  input  1  terminate the running command.
- alu_f  output  3  ALU f select.
- alu_write_cz  output  1  ALU register/flag write enable.
- alu_aBus  output  DATA_W  ALU aBus operand.
- alu_cBus  input  DATA_W  ALU result.
- alu_CF  input  1  ALU carry flag.
- alu_ZF  input  1  ALU zero flag.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- done_result  output  DATA_W  alu_cBus captured at completion.
- done_cf  output  1  alu_CF captured at completion.
- done_zf  output  1  alu_ZF captured at completion.
- done_iters  output  CNT_W+1  number of issues performed.
- done_aborted  output  1  command ended by abort.

Behaviour:
- Reset (rstn_SEQ low at a rising edge) forces the following; reset mid-command drops the command with no done pulse:
  - state IDLE, alu_write_cz=0, alu_f=000, alu_aBus=0.
  - busy=0, done=0, cmd_ready=1.
  - all done_* outputs and internal counters 0.
- States: IDLE, ISSUE, CHECK, DONE.
- IDLE:
  - cmd_ready=1, alu_write_cz=0, alu_f=000 (NOP).
  - On cmd_valid&cmd_ready, latch op, cnt, until_z and data, clear the iteration counter, go to ISSUE.
- ISSUE (one cycle):
  - alu_f=latched op, alu_aBus=latched data, alu_write_cz=1, busy=1.
  - The ALU writes at the ending edge; the iteration counter increments at that edge; go to CHECK.
- CHECK (one cycle):
  - alu_write_cz=0, alu_f=latched op, busy=1.
  - ALU outputs now reflect the last issue; sample alu_cBus/CF/ZF into the done_* registers at the ending edge.
  - Terminate (go to DONE) if iter==cnt+1, or if until_z and alu_ZF=1; otherwise go to ISSUE.
- DONE (one cycle): done=1, busy=0, cmd_ready=0; go to IDLE. done_* outputs hold until the next DONE or reset.
- Latency: command accepted at edge T0; issue k (1-based) occupies cycle 2k-1 after T0; done is asserted in cycle 2n+1 for n issues.
- Abort:
  - If abort is sampled high in ISSUE, that issue still writes; next state is CHECK with forced termination and done_aborted=1.
  - If sampled high in CHECK, terminate with done_aborted=1.
  - If the normal termination condition holds in the same CHECK, done_aborted=0 (normal termination wins).
  - Abort in IDLE or DONE is ignored.
- Count wrap: cmd_cnt = all ones gives 2^CNT_W issues; the iteration counter is CNT_W+1 bits, so no wrap.
- cmd_valid asserted outside IDLE is not accepted; the command holds until cmd_ready.
- alu_write_cz is never 1 outside ISSUE.

Decomposition:
- Package alu_seq_pkg:
  - alu_op_e enum (the 8 f codes above).
  - seq_state_e enum (IDLE/ISSUE/CHECK/DONE).
  - ALU_NOP constant = 3'b000.
  - DATA_W default.
- Sub-module: none required; the iteration counter and terminate compare stay inline.

Test Plan:
- Reset then idle -> cmd_ready=1, alu_write_cz=0, alu_f=000, done_* all 0; assert rstn_SEQ low mid-ISSUE -> next cycle IDLE, write_cz=0, no done pulse.
- Load: op=000, data=0xFF, cnt=0 -> single ISSUE cycle with write_cz=1; done in cycle 3 after accept; done_result=0xFF, done_zf=0, done_iters=1.
- Increment until zero: preload A=0xFE, then op=010, cnt=7, until_z=1 -> two issues (0xFF, 0x00); done_result=0x00, done_zf=1, done_cf=1, done_iters=2, done cycle 5.
- Full repeat: preload A=0x00, op=010, cnt=4'hF, until_z=0 -> 16 issues; done_result=0x10, done_iters=16, done in cycle 33.
- Abort: op=010, cnt=9, abort pulsed during the 3rd ISSUE -> exactly 3 write_cz pulses; done_aborted=1, done_iters=3; abort coinciding with the final CHECK -> done_aborted=0.
- Back-to-back: cmd_valid held high with a second command -> second accept only in the IDLE cycle after DONE; no write_cz while in DONE/IDLE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam logic [2:0] ALU_NOP = 3'b000;

  typedef enum logic [2:0] {
    OP_LOAD_A = 3'b000,
    OP_B_EQ_A = 3'b001,
    OP_INC_A  = 3'b010,
    OP_INC_B  = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_AND    = 3'b110,
    OP_OR     = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequencer that issues one ALU command up to 2^CNT_W times, with
// optional early stop on the zero flag and an abort input, then reports
// the final ALU result, flags and issue count with a one-cycle done pulse.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_SEQ,
  input  logic              rstn_SEQ,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              cmd_until_z,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              abort,
  output logic [2:0]        alu_f,
  output logic              alu_write_cz,
  output logic [DATA_W-1:0] alu_aBus,
  input  logic [DATA_W-1:0] alu_cBus,
  input  logic              alu_CF,
  input  logic              alu_ZF,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] done_result,
  output logic              done_cf,
  output logic              done_zf,
  output logic [CNT_W:0]    done_iters,
  output logic              done_aborted
);

  seq_state_e        state_q, state_d;
  alu_op_e           op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              untilZ_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W:0]    iter_q;
  logic              abortPend_q;

  logic [DATA_W-1:0] doneResult_q;
  logic              doneCf_q;
  logic              doneZf_q;
  logic [CNT_W:0]    doneIters_q;
  logic              doneAborted_q;

  logic [CNT_W:0]    lastIter;
  logic              accept;
  logic              normalTerm;
  logic              abortTerm;
  logic              finish;

  // The counter is one bit wider than the count so cnt = all ones means 2^CNT_W issues.
  assign lastIter = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  assign done_result  = doneResult_q;
  assign done_cf      = doneCf_q;
  assign done_zf      = doneZf_q;
  assign done_iters   = doneIters_q;
  assign done_aborted = doneAborted_q;

  // State register.
  always_ff @(posedge clk_SEQ) begin
    if (!rstn_SEQ) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and ALU drive; ALU writes only happen in ISSUE.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    alu_f        = ALU_NOP;
    alu_write_cz = 1'b0;
    alu_aBus     = '0;
    accept       = 1'b0;
    normalTerm   = 1'b0;
    abortTerm    = 1'b0;
    finish       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy         = 1'b1;
        alu_f        = op_q;
        alu_aBus     = data_q;
        alu_write_cz = 1'b1;
        state_d      = ST_CHECK;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        alu_f      = op_q;
        alu_aBus   = data_q;
        normalTerm = (iter_q == lastIter) || (untilZ_q && alu_ZF);
        abortTerm  = abortPend_q || abort;
        if (normalTerm || abortTerm) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command latch, issue counter, pending abort and the held completion report.
  always_ff @(posedge clk_SEQ) begin
    if (!rstn_SEQ) begin
      op_q          <= OP_LOAD_A;
      cnt_q         <= '0;
      untilZ_q      <= 1'b0;
      data_q        <= '0;
      iter_q        <= '0;
      abortPend_q   <= 1'b0;
      doneResult_q  <= '0;
      doneCf_q      <= 1'b0;
      doneZf_q      <= 1'b0;
      doneIters_q   <= '0;
      doneAborted_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= alu_op_e'(cmd_op);
        cnt_q       <= cmd_cnt;
        untilZ_q    <= cmd_until_z;
        data_q      <= cmd_data;
        iter_q      <= '0;
        abortPend_q <= 1'b0;
      end
      if (state_q == ST_ISSUE) begin
        iter_q      <= iter_q + {{CNT_W{1'b0}}, 1'b1};
        abortPend_q <= abort;
      end
      if (finish) begin
        doneResult_q  <= alu_cBus;
        doneCf_q      <= alu_CF;
        doneZf_q      <= alu_ZF;
        doneIters_q   <= iter_q;
        doneAborted_q <= abortTerm && !normalTerm;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural 8-bit ALU sits on the ALU side
// and a command-level reference predicts issue counts, results and timing.
module tb_alu_sequencer;

  logic       clk_SEQ = 1'b0;
  logic       rstn_SEQ;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic       cmd_until_z;
  logic [7:0] cmd_data;
  logic       abort;
  logic [2:0] alu_f;
  logic       alu_write_cz;
  logic [7:0] alu_aBus;
  logic [7:0] alu_cBus;
  logic       alu_CF;
  logic       alu_ZF;
  logic       busy;
  logic       done;
  logic [7:0] done_result;
  logic       done_cf;
  logic       done_zf;
  logic [4:0] done_iters;
  logic       done_aborted;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       cf;
  } aluRes_t;

  logic [7:0] envA  = 8'h00;
  logic [7:0] envB  = 8'h00;
  logic [7:0] envC  = 8'h00;
  logic       envCf = 1'b0;
  logic       envZf = 1'b0;
  aluRes_t    envNext;

  logic [7:0] refA = 8'h00;
  logic [7:0] refB = 8'h00;

  alu_sequencer dut (
    .clk_SEQ      (clk_SEQ),
    .rstn_SEQ     (rstn_SEQ),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_cnt      (cmd_cnt),
    .cmd_until_z  (cmd_until_z),
    .cmd_data     (cmd_data),
    .abort        (abort),
    .alu_f        (alu_f),
    .alu_write_cz (alu_write_cz),
    .alu_aBus     (alu_aBus),
    .alu_cBus     (alu_cBus),
    .alu_CF       (alu_CF),
    .alu_ZF       (alu_ZF),
    .busy         (busy),
    .done         (done),
    .done_result  (done_result),
    .done_cf      (done_cf),
    .done_zf      (done_zf),
    .done_iters   (done_iters),
    .done_aborted (done_aborted)
  );

  // Free-running 10 ns clock.
  always #5 clk_SEQ = ~clk_SEQ;

  // One ALU operation on registers A/B with operand d; result goes to A except B=A and B+1.
  function automatic aluRes_t aluEval(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] d);
    aluRes_t s;
    logic [8:0] w;
    s.a  = a;
    s.b  = b;
    s.r  = 8'h00;
    s.cf = 1'b0;
    w    = 9'h000;
    case (op)
      3'd0: begin s.a = d; s.r = d; end
      3'd1: begin s.b = a; s.r = a; end
      3'd2: begin w = {1'b0, a} + 9'd1; s.a = w[7:0]; s.r = w[7:0]; s.cf = w[8]; end
      3'd3: begin w = {1'b0, b} + 9'd1; s.b = w[7:0]; s.r = w[7:0]; s.cf = w[8]; end
      3'd4: begin w = {1'b0, a} + {1'b0, b}; s.a = w[7:0]; s.r = w[7:0]; s.cf = w[8]; end
      3'd5: begin w = {1'b0, a} - {1'b0, b}; s.a = w[7:0]; s.r = w[7:0]; s.cf = w[8]; end
      3'd6: begin s.r = a & b; s.a = s.r; end
      default: begin s.r = a | b; s.a = s.r; end
    endcase
    return s;
  endfunction

  // The ALU model's next state, computed from whatever the sequencer drives.
  always_comb envNext = aluEval(alu_f, envA, envB, alu_aBus);

  // The ALU registers its result and flags whenever write_cz is high at an edge.
  always @(posedge clk_SEQ) begin
    if (alu_write_cz) begin
      envA  <= envNext.a;
      envB  <= envNext.b;
      envC  <= envNext.r;
      envCf <= envNext.cf;
      envZf <= (envNext.r == 8'h00);
    end
  end

  assign alu_cBus = envC;
  assign alu_CF   = envCf;
  assign alu_ZF   = envZf;

  // Count a comparison and report it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Command-level prediction: repeat the op until count, zero stop or abort after issue abortIssue.
  task automatic modelCommand(input logic [2:0] op, input logic [3:0] cnt, input logic untilZ,
                              input logic [7:0] data, input int abortIssue,
                              output int n, output logic [7:0] res, output logic cf,
                              output logic zf, output logic aborted);
    aluRes_t s;
    n       = 0;
    res     = 8'h00;
    cf      = 1'b0;
    zf      = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= int'(cnt) + 1; k++) begin
      s    = aluEval(op, refA, refB, data);
      refA = s.a;
      refB = s.b;
      res  = s.r;
      cf   = s.cf;
      zf   = (s.r == 8'h00);
      n    = k;
      if (k == int'(cnt) + 1 || (untilZ && zf)) break;
      if (k == abortIssue) begin
        aborted = 1'b1;
        break;
      end
    end
  endtask

  // Present one command, optionally raise abort during cycle abortCycle after acceptance,
  // and compare the cycle-by-cycle behaviour and the completion report with the prediction.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] cnt,
                               input logic untilZ, input logic [7:0] data, input int abortCycle);
    int         expN;
    logic [7:0] expRes;
    logic       expCf;
    logic       expZf;
    logic       expAb;
    int         c;
    int         doneCycle;
    int         patternErr;
    logic       expW;
    modelCommand(op, cnt, untilZ, data, (abortCycle > 0) ? (abortCycle + 1) / 2 : 0,
                 expN, expRes, expCf, expZf, expAb);
    @(negedge clk_SEQ);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_cnt     = cnt;
    cmd_until_z = untilZ;
    cmd_data    = data;
    @(posedge clk_SEQ);
    c          = 0;
    doneCycle  = 0;
    patternErr = 0;
    while (doneCycle == 0 && c < 40) begin
      @(negedge clk_SEQ);
      c++;
      cmd_valid = 1'b0;
      expW = (c % 2 == 1) && (c <= 2 * expN - 1);
      if (alu_write_cz !== expW) patternErr++;
      if (alu_write_cz === 1'b1 && (alu_f !== op || alu_aBus !== data)) patternErr++;
      if (busy !== (c <= 2 * expN)) patternErr++;
      if (cmd_ready !== 1'b0) patternErr++;
      if (done === 1'b1) doneCycle = c;
      abort = (c == abortCycle);
    end
    abort = 1'b0;
    checkOutput({tag, "_done_cycle"}, 32'(doneCycle), 32'(2 * expN + 1));
    checkOutput({tag, "_result"}, 32'(done_result), 32'(expRes));
    checkOutput({tag, "_flags"}, 32'({done_cf, done_zf}), 32'({expCf, expZf}));
    checkOutput({tag, "_iters"}, 32'(done_iters), 32'(expN));
    checkOutput({tag, "_aborted"}, 32'(done_aborted), 32'(expAb));
    @(negedge clk_SEQ);
    if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_write_cz !== 1'b0) patternErr++;
    if (done_result !== expRes || done_iters !== 5'(expN)) patternErr++;
    checkOutput({tag, "_pattern"}, 32'(patternErr), 32'd0);
  endtask

  // Directed scenarios followed by randomized commands.
  initial begin
    int         doneCount;
    int         errB2B;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       cf1;
    logic       zf1;
    logic       ab1;
    int         n1;
    int         cntR;
    aluRes_t    s;

    rstn_SEQ    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_cnt     = 4'd0;
    cmd_until_z = 1'b0;
    cmd_data    = 8'h00;
    abort       = 1'b0;
    repeat (3) @(posedge clk_SEQ);
    @(negedge clk_SEQ);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_alu", 32'({alu_write_cz, alu_f, alu_aBus}), 32'd0);
    checkOutput("rst_status", 32'({busy, done}), 32'd0);
    checkOutput("rst_done_regs",
                32'({done_result, done_cf, done_zf, done_iters, done_aborted}), 32'd0);
    rstn_SEQ = 1'b1;

    applyStimulus("load_ff", 3'd0, 4'd0, 1'b0, 8'hFF, 0);
    checkOutput("load_ff_const", 32'({done_result, done_zf, done_iters}), 32'({8'hFF, 1'b0, 5'd1}));

    applyStimulus("preload_fe", 3'd0, 4'd0, 1'b0, 8'hFE, 0);
    applyStimulus("inc_until_z", 3'd2, 4'd7, 1'b1, 8'h00, 0);
    checkOutput("inc_until_z_const", 32'({done_result, done_cf, done_zf, done_iters}),
                32'({8'h00, 1'b1, 1'b1, 5'd2}));

    applyStimulus("preload_00", 3'd0, 4'd0, 1'b0, 8'h00, 0);
    applyStimulus("full_repeat", 3'd2, 4'hF, 1'b0, 8'h00, 0);
    checkOutput("full_repeat_const", 32'({done_result, done_iters}), 32'({8'h10, 5'd16}));

    applyStimulus("abort_issue3", 3'd2, 4'd9, 1'b0, 8'h00, 5);
    checkOutput("abort_issue3_const", 32'({done_aborted, done_iters}), 32'({1'b1, 5'd3}));
    applyStimulus("abort_check2", 3'd2, 4'd9, 1'b0, 8'h00, 4);
    applyStimulus("abort_final", 3'd2, 4'd2, 1'b0, 8'h00, 6);
    checkOutput("abort_final_const", 32'({done_aborted, done_iters}), 32'({1'b0, 5'd3}));

    @(negedge clk_SEQ);
    cmd_valid   = 1'b1;
    cmd_op      = 3'd2;
    cmd_cnt     = 4'd5;
    cmd_until_z = 1'b0;
    cmd_data    = 8'h00;
    @(posedge clk_SEQ);
    @(negedge clk_SEQ);
    cmd_valid = 1'b0;
    checkOutput("rst_mid_issue_wcz", 32'(alu_write_cz), 32'd1);
    rstn_SEQ = 1'b0;
    @(posedge clk_SEQ);
    s    = aluEval(3'd2, refA, refB, 8'h00);
    refA = s.a;
    refB = s.b;
    @(negedge clk_SEQ);
    checkOutput("rst_mid_state",
                32'({alu_write_cz, cmd_ready, busy, done, alu_f}), 32'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0}));
    checkOutput("rst_mid_done_regs",
                32'({done_result, done_cf, done_zf, done_iters, done_aborted}), 32'd0);
    rstn_SEQ  = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_SEQ);
      if (done === 1'b1 || alu_write_cz === 1'b1) doneCount++;
    end
    checkOutput("rst_mid_no_done", 32'(doneCount), 32'd0);

    modelCommand(3'd0, 4'd0, 1'b0, 8'h11, 0, n1, r1, cf1, zf1, ab1);
    modelCommand(3'd2, 4'd0, 1'b0, 8'h11, 0, n1, r2, cf1, zf1, ab1);
    errB2B = 0;
    @(negedge clk_SEQ);
    cmd_valid   = 1'b1;
    cmd_op      = 3'd0;
    cmd_cnt     = 4'd0;
    cmd_until_z = 1'b0;
    cmd_data    = 8'h11;
    @(posedge clk_SEQ);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_SEQ);
      if (alu_write_cz !== (c == 1 || c == 5)) errB2B++;
      if (done !== (c == 3 || c == 7)) errB2B++;
      if (cmd_ready !== (c == 4 || c == 8)) errB2B++;
      if (c == 5 && alu_f !== 3'd2) errB2B++;
      if (c == 3 && done_result !== r1) errB2B++;
      if (c == 1) cmd_op = 3'd2;
      if (c == 5) cmd_valid = 1'b0;
    end
    checkOutput("b2b_pattern", 32'(errB2B), 32'd0);
    checkOutput("b2b_result2", 32'(done_result), 32'(r2));

    for (int i = 0; i < 25; i++) begin
      cntR = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      applyStimulus($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 4'(cntR),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * cntR + 3)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
